// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one registered ALU between the
// execute stage (requester 0) and the address/PC unit (requester 1).
// Each accepted request is issued to the ALU for one cycle. The result is
// captured one cycle later and returned on the winner's response channel.
// Unsupported opcodes are answered with an error and never reach the ALU.
module alu_req_arbiter #(
    parameter int W   = 32,
    parameter int OPW = 5
) (
    input  logic           clk,
    input  logic           rstn,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [OPW-1:0] req0_op,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [OPW-1:0] req1_op,

    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [W-1:0]   rsp0_data,
    output logic           rsp0_zero,
    output logic           rsp0_err,

    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [W-1:0]   rsp1_data,
    output logic           rsp1_zero,
    output logic           rsp1_err,

    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_c,
    input  logic [7:0]     alu_zero
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t         state_q,      state_d;
    logic           last_grant_q, last_grant_d;
    logic           gnt_q,        gnt_d;
    logic [W-1:0]   alu_a_q,      alu_a_d;
    logic [W-1:0]   alu_b_q,      alu_b_d;
    logic [OPW-1:0] alu_op_q,     alu_op_d;
    logic [1:0]     rsp_valid_q,  rsp_valid_d;
    logic [W-1:0]   data_q,       data_d;
    logic           zero_q,       zero_d;
    logic           err_q,        err_d;

    logic           grant;
    logic           accept;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [OPW-1:0] sel_op;
    logic           sel_supported;
    logic           rsp_taken;

    // Only bit 0 of the ALU zero flag carries meaning.
    logic           unused_zero_bits;
    assign unused_zero_bits = ^alu_zero[7:1];

    // Round-robin grant selection and the combinational ready handshake.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
        accept        = (state_q == IDLE) && (req0_valid || req1_valid);
        req0_ready    = accept && !grant;
        req1_ready    = accept && grant;
        sel_a         = grant ? req1_a  : req0_a;
        sel_b         = grant ? req1_b  : req0_b;
        sel_op        = grant ? req1_op : req0_op;
        sel_supported = (sel_op == OPW'(1)) || (sel_op == OPW'(2)) ||
                        (sel_op == OPW'(3));
        rsp_taken     = gnt_q ? rsp1_ready : rsp0_ready;
    end

    // Next-state and registered-output computation for the arbiter FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = '0;
        rsp_valid_d  = rsp_valid_q;
        data_d       = data_q;
        zero_d       = zero_q;
        err_d        = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    gnt_d = grant;
                    if (sel_supported) begin
                        alu_a_d  = sel_a;
                        alu_b_d  = sel_b;
                        alu_op_d = sel_op;
                        err_d    = 1'b0;
                        state_d  = ISSUE;
                    end else begin
                        // Error path: operands are not forwarded so the ALU
                        // inputs stay untouched; the response is ready next cycle.
                        data_d             = '0;
                        zero_d             = 1'b0;
                        err_d              = 1'b1;
                        rsp_valid_d[grant] = 1'b1;
                        state_d            = RESP;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                data_d             = alu_c;
                zero_d             = alu_zero[0];
                rsp_valid_d[gnt_q] = 1'b1;
                state_d            = RESP;
            end
            RESP: begin
                if (rsp_taken) begin
                    rsp_valid_d  = '0;
                    last_grant_d = gnt_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= '0;
            data_q       <= '0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            data_q       <= data_d;
            zero_q       <= zero_d;
            err_q        <= err_d;
        end
    end

    // Response channels: only the granted channel shows the held result.
    always_comb begin
        rsp0_valid = rsp_valid_q[0];
        rsp0_data  = rsp_valid_q[0] ? data_q : '0;
        rsp0_zero  = rsp_valid_q[0] & zero_q;
        rsp0_err   = rsp_valid_q[0] & err_q;
        rsp1_valid = rsp_valid_q[1];
        rsp1_data  = rsp_valid_q[1] ? data_q : '0;
        rsp1_zero  = rsp_valid_q[1] & zero_q;
        rsp1_err   = rsp_valid_q[1] & err_q;
        alu_a      = alu_a_q;
        alu_b      = alu_b_q;
        alu_op     = alu_op_q;
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: transaction-level check of alu_req_arbiter against a
// round-robin / latency / result model, with a simple registered ALU model.
module tb_alu_req_arbiter;

    localparam int W   = 32;
    localparam int OPW = 5;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Requester-side stimulus state, indexed by requester id.
    logic           v   [2];
    logic [W-1:0]   ra  [2];
    logic [W-1:0]   rb  [2];
    logic [OPW-1:0] rop [2];
    logic           rr  [2];

    logic           req0_ready, req1_ready;
    logic           rsp0_valid, rsp1_valid;
    logic [W-1:0]   rsp0_data,  rsp1_data;
    logic           rsp0_zero,  rsp1_zero;
    logic           rsp0_err,   rsp1_err;
    logic [W-1:0]   alu_a, alu_b;
    logic [OPW-1:0] alu_op;
    logic [W-1:0]   alu_c    = '0;
    logic [7:0]     alu_zero = '0;

    alu_req_arbiter #(.W(W), .OPW(OPW)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(v[0]), .req0_ready(req0_ready), .req0_a(ra[0]), .req0_b(rb[0]), .req0_op(rop[0]),
        .req1_valid(v[1]), .req1_ready(req1_ready), .req1_a(ra[1]), .req1_b(rb[1]), .req1_op(rop[1]),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rr[0]), .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rr[1]), .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .alu_zero(alu_zero)
    );

    // ALU semantics used by both the ALU model and the expected results.
    function automatic logic [W-1:0] alu_f(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            5'd1:    return b << 12;
            5'd2:    return a + (b << 12);
            5'd3:    return a + b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Registered ALU: updates on a non-zero opcode, holds otherwise; the
    // unused zero-flag bits carry noise.
    always @(posedge clk) begin
        if (alu_op != '0) begin
            alu_c    <= alu_f(alu_op, alu_a, alu_b);
            alu_zero <= {7'($urandom), (alu_f(alu_op, alu_a, alu_b) == '0)};
        end
    end

    int checks   = 0;
    int failures = 0;
    int last_grant;
    int last_acc = 0;
    logic [W-1:0] last_rsp_data;
    logic         last_rsp_zero;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic [OPW-1:0] op);
        ra[n] = a; rb[n] = b; rop[n] = op; v[n] = 1'b1;
    endtask

    task automatic rand_req(input int n, input bit add_only);
        int k;
        k = $urandom_range(0, 9);
        ra[n] = $urandom;
        rb[n] = $urandom;
        if (add_only)   rop[n] = 5'd3;
        else if (k < 2) rop[n] = 5'd1;
        else if (k < 4) rop[n] = 5'd2;
        else if (k < 7) rop[n] = 5'd3;
        else if (k < 8) rop[n] = 5'd0;
        else            rop[n] = 5'($urandom_range(4, 31));
        if ($urandom_range(0, 4) == 0) rb[n] = -ra[n];
        v[n] = 1'b1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        v[0] = 1'b0; v[1] = 1'b0; rr[0] = 1'b0; rr[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        last_grant = 1;
    endtask

    // One full transaction from an IDLE cycle. mode: 0 winner drops valid,
    // 1 winner re-requests a random add, 2 winner randomly re-requests.
    task automatic run_txn(input int bp, input int mode, input bit chk_gap);
        int g, lat, nops;
        bit seen, sup;
        logic [W-1:0]   ea, eb, exp_d;
        logic [OPW-1:0] eop;
        logic           exp_z;
        if (v[0] && v[1]) g = 1 - last_grant;
        else if (v[0])    g = 0;
        else              g = 1;
        rr[0] = (bp == 0); rr[1] = (bp == 0);
        @(negedge clk);
        check("ready0", req0_ready, g == 0);
        check("ready1", req1_ready, g == 1);
        ea = ra[g]; eb = rb[g]; eop = rop[g];
        sup   = (eop >= 5'd1) && (eop <= 5'd3);
        exp_d = sup ? alu_f(eop, ea, eb) : '0;
        exp_z = sup && (exp_d == '0);
        @(posedge clk);
        #1;
        if (chk_gap) check("accept_gap", cyc - last_acc, 4);
        last_acc = cyc;
        if (mode == 1) rand_req(g, 1'b1);
        else if (mode == 2 && $urandom_range(0, 1) == 1) rand_req(g, 1'b0);
        else v[g] = 1'b0;
        lat = 0; nops = 0; seen = 0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            if (alu_op != '0) begin
                nops++;
                check("alu_op_val", alu_op, eop);
                check("alu_op_cycle", lat, 1);
            end
            check("other_rsp_idle", (g == 1) ? rsp0_valid : rsp1_valid, 1'b0);
            check("ready_busy", {req0_ready, req1_ready}, 2'b00);
            seen = (g == 1) ? rsp1_valid : rsp0_valid;
            if (!seen) begin
                @(posedge clk);
                #1;
            end
        end
        if (!seen) begin
            check("rsp_timeout", 1'b0, 1'b1);
            return;
        end
        check("latency", lat, sup ? 3 : 1);
        check("alu_issues", nops, sup ? 1 : 0);
        for (int i = 0; i <= bp; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
                @(negedge clk);
                check("bp_valid", (g == 1) ? rsp1_valid : rsp0_valid, 1'b1);
            end
            check("rsp_data", (g == 1) ? rsp1_data : rsp0_data, exp_d);
            check("rsp_zero", (g == 1) ? rsp1_zero : rsp0_zero, exp_z);
            check("rsp_err",  (g == 1) ? rsp1_err  : rsp0_err,  !sup);
        end
        last_rsp_data = (g == 1) ? rsp1_data : rsp0_data;
        last_rsp_zero = (g == 1) ? rsp1_zero : rsp0_zero;
        rr[g] = 1'b1;
        @(posedge clk);
        #1;
        last_grant = g;
        check("rsp_done", (g == 1) ? rsp1_valid : rsp0_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int n = 0; n < 2; n++) begin
            v[n] = 1'b0; ra[n] = '0; rb[n] = '0; rop[n] = '0; rr[n] = 1'b0;
        end
        rstn = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
        check("rst_rsp_data", {rsp0_data, rsp1_data}, 64'd0);
        check("rst_rsp_flags", {rsp0_zero, rsp0_err, rsp1_zero, rsp1_err}, 4'd0);
        check("rst_alu_ab", {alu_a, alu_b}, 64'd0);
        check("rst_alu_op", alu_op, 5'd0);
        do_reset();

        // Single add on requester 0.
        set_req(0, 32'd5, 32'd7, 5'd3);
        run_txn(0, 0, 0);
        check("add_5_7", last_rsp_data, 32'd12);

        // Simultaneous requests after reset: requester 0 wins the first tie.
        do_reset();
        set_req(0, 32'd1, 32'd1, 5'd3);
        set_req(1, 32'd2, 32'd2, 5'd3);
        run_txn(0, 0, 0);
        check("tie_first_data", last_rsp_data, 32'd2);
        run_txn(0, 0, 0);
        check("tie_second_data", last_rsp_data, 32'd4);

        // Continuous contention: alternating grants, one accept every 4 cycles.
        rand_req(0, 1'b1);
        rand_req(1, 1'b1);
        for (int i = 0; i < 4; i++) run_txn(0, 1, i > 0);
        v[0] = 1'b0; v[1] = 1'b0;

        // Zero result and wrap-around.
        set_req(0, 32'd3, -32'sd3, 5'd3);
        run_txn(0, 0, 0);
        check("zero_data", last_rsp_data, 32'd0);
        check("zero_flag", last_rsp_zero, 1'b1);
        set_req(1, 32'h7FFF_FFFF, 32'd1, 5'd3);
        run_txn(0, 0, 0);
        check("wrap_data", last_rsp_data, 32'h8000_0000);
        check("wrap_flag", last_rsp_zero, 1'b0);

        // Unsupported opcode on requester 1.
        set_req(1, 32'h1234, 32'h5678, 5'h1F);
        run_txn(0, 0, 0);

        // Backpressure for 5 cycles, then reset during WAIT of the next one.
        do_reset();
        set_req(0, 32'd40, 32'd2, 5'd3);
        run_txn(5, 0, 0);
        set_req(0, 32'd100, 32'd23, 5'd3);
        rr[0] = 1'b1;
        @(negedge clk);
        check("rst2_ready", req0_ready, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check("rst2_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
        check("rst2_alu_op", alu_op, 5'd0);
        check("rst2_alu_ab", {alu_a, alu_b}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        last_grant = 1;
        check("rst2_no_rsp", rsp0_valid, 1'b0);
        run_txn(0, 0, 0);
        check("reissue_data", last_rsp_data, 32'd123);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            for (int n = 0; n < 2; n++)
                if (!v[n] && $urandom_range(0, 1) == 1) rand_req(n, 1'b0);
            if (!v[0] && !v[1]) rand_req(int'($urandom_range(0, 1)), 1'b0);
            run_txn(int'($urandom_range(0, 3)), 2, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
